if_stage_reg: RTL and testbench
===============================

// Module: if_stage_reg
// PURPOSE
//  Fetch stage plus IF/ID pipeline register for the 5-stage core.
//  Holds the PC, drives the instruction-memory address, and latches the fetched word and PC+4 into ID.
//  Consumes the hazard unit's Hazard output as 'freeze' and the EXE branch decision as 'flush'.
//  Sits directly upstream of ID, where src1/src2 for the hazard check are decoded.
// PARAMETERS
//  PC_W        32            PC / address width
//  RESET_PC    0             PC value after reset
//  NOP_INSTR   32'h0000_0000 word injected into ID on reset/flush (ANDEQ r0,r0,r0)
//  STALL_CNT_W 16            width of freeze-cycle counter (STALL_COUNT_EN only)
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           asynchronous reset, active-low
//  freeze       in   1           hazard stall from hazardUnit.Hazard
//  flush        in   1           branch taken in EXE; redirect fetch
//  branch_addr  in   PC_W        redirect target, valid when flush=1
//  imem_addr    out  PC_W        = PC; combinational read address
//  imem_rdata   in   32          instruction at imem_addr, same cycle
//  id_pc        out  PC_W        PC+4 of instruction held in ID
//  id_instr     out  32          instruction held in ID
//  id_valid     out  1           1 = id_instr is a real fetched instruction
//  stall_cnt    out  STALL_CNT_W saturating freeze-cycle count (STALL_COUNT_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): PC=RESET_PC, id_pc=0, id_instr=NOP_INSTR, id_valid=0, stall_cnt=0.
//  - Per posedge clk, priority flush > freeze > run:
//    * flush=1:  PC<=branch_addr with bits[1:0] forced to 0; id_instr<=NOP_INSTR; id_valid<=0; id_pc<=0.
//                Flush wins even if freeze=1, so a taken branch never deadlocks on a stale hazard.
//    * freeze=1, flush=0: PC, id_pc, id_instr and id_valid all hold.
//    * run:      PC<=PC+4; id_pc<=PC+4; id_instr<=imem_rdata; id_valid<=1.
//  - Fetch latency: the word at imem_addr appears on id_instr 1 cycle later. A branch costs 2 bubbles (IF plus ID).
//  - PC arithmetic is modulo 2^PC_W: 0xFFFF_FFFC+4 -> 0, no flag.
//  - imem_addr is a pure register output with no combinational path from freeze or flush.
//  - Reset asserted mid-stall or mid-flush: all state is forced to reset values immediately.
//    The first cycle after release is a normal fetch from RESET_PC.
//  - freeze is sampled only at the clock edge; glitches between edges are ignored.
// CONFIGURATION
//  STALL_COUNT_EN defined:
//    stall_cnt increments by 1 each posedge with freeze=1 and flush=0.
//    It saturates at all-ones and clears only on reset.
//  STALL_COUNT_EN undefined: stall_cnt port and counter are absent; there is no other difference.
// TESTING
//  1. Reset release, imem returns 0xE3A01005 at addr 0 -> next cycle id_instr=0xE3A01005, id_pc=4, id_valid=1, imem_addr=4.
//  2. freeze=1 for 3 cycles at PC=8 -> imem_addr stays 8 and ID holds.
//     Release -> fetch resumes at 8. stall_cnt=3 with STALL_COUNT_EN.
//  3. flush=1, branch_addr=0x40 at PC=0x10 -> next imem_addr=0x40, id_valid=0, id_instr=NOP_INSTR.
//     The following cycle id_instr=mem[0x40].
//  4. flush=1 and freeze=1 in the same cycle, branch_addr=0x103 -> PC=0x100, ID flushed, stall_cnt unchanged.
//  5. PC=0xFFFF_FFFC, run -> imem_addr=0, id_pc=0.
//     rst pulsed low mid-freeze -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/if_stage_reg.sv
// ---------------------------------------------------------------------------
// if_stage_reg
//
// Fetch stage plus IF/ID pipeline register for the 5-stage core.
// Holds the program counter, presents it as the instruction-memory read
// address, and latches the fetched word together with PC+4 into ID.
// The hazard unit's stall request arrives as 'freeze' and the EXE-stage
// taken-branch decision arrives as 'flush'. Flush has priority over freeze
// so that a taken branch can never deadlock behind a stale hazard.
//
// Optional feature (compile-time macro STALL_COUNT_EN):
//   When defined, a saturating counter of frozen cycles is kept and exposed
//   on 'stall_cnt'. When undefined, the port and counter do not exist.
//
// Ports
//   clk          in   1            rising-edge clock
//   rst          in   1            asynchronous reset, active-low
//   freeze       in   1            hazard stall request
//   flush        in   1            taken branch in EXE, redirect fetch
//   branch_addr  in   PC_W         redirect target, used when flush=1
//   imem_addr    out  PC_W         instruction-memory read address (= PC)
//   imem_rdata   in   32           word at imem_addr, same cycle
//   id_pc        out  PC_W         PC+4 of the instruction held in ID
//   id_instr     out  32           instruction held in ID
//   id_valid     out  1            id_instr is a real fetched instruction
//   stall_cnt    out  STALL_CNT_W  saturating frozen-cycle count
//                                  (only with STALL_COUNT_EN)
// ---------------------------------------------------------------------------
module if_stage_reg #(
    parameter int               PC_W        = 32,
    parameter logic [PC_W-1:0]  RESET_PC    = '0,
    parameter logic [31:0]      NOP_INSTR   = 32'h0000_0000,
    parameter int               STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic [PC_W-1:0]        branch_addr,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [PC_W-1:0]        id_pc,
    output logic [31:0]            id_instr,
    output logic                   id_valid
`ifdef STALL_COUNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_target;

    // Wraps modulo 2^PC_W by construction of the fixed-width add.
    assign pc_plus4 = pc + PC_W'(4);

    // Instructions are word aligned, so the low two target bits are dropped.
    assign branch_target = branch_addr & ~PC_W'(3);

    // Driven straight from the PC flop: no combinational path from
    // freeze or flush reaches the memory address.
    assign imem_addr = pc;

    // Program counter: flush redirects, freeze holds, otherwise advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= branch_target;
        end else if (!freeze) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID register: a flush injects a bubble, a freeze holds the current
    // contents, and a normal cycle captures the word being fetched now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_pc    <= '0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (!freeze) begin
            id_pc    <= pc_plus4;
            id_instr <= imem_rdata;
            id_valid <= 1'b1;
        end
    end

`ifdef STALL_COUNT_EN
    // Only genuine stall cycles are counted; a flush overriding a freeze
    // is not a stall. The count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (freeze && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_if_stage_reg
//
// Self-checking bench for if_stage_reg. A directed vector table covers the
// basic fetch/freeze/flush behaviour, hand sequences cover wraparound,
// asynchronous reset and mid-cycle freeze glitches, and a randomized phase
// is compared against a behavioural pipeline model kept in this file.
// Build with +define+STALL_COUNT_EN to also check the stall counter.
// ---------------------------------------------------------------------------
module tb_if_stage_reg;

    localparam int          PC_W        = 32;
    localparam int          STALL_CNT_W = 16;
    localparam logic [31:0] NOP         = 32'h0000_0000;

    logic              clk;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic [PC_W-1:0]   branch_addr;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic [PC_W-1:0]   id_pc;
    logic [31:0]       id_instr;
    logic              id_valid;
`ifdef STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_stage_reg #(
        .PC_W        (PC_W),
        .RESET_PC    ('0),
        .NOP_INSTR   (NOP),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .branch_addr (branch_addr),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_valid    (id_valid)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // ------------------------------------------------------------------
    // Behavioural model: the architectural state of IF and ID.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_valid;
    int unsigned m_stall;

    task automatic model_reset();
        m_pc       = 32'h0;
        m_id_pc    = 32'h0;
        m_id_instr = NOP;
        m_valid    = 1'b0;
        m_stall    = 0;
    endtask

    task automatic model_step(input logic fz, input logic fl, input logic [31:0] ba);
        if (fl) begin
            m_pc       = {ba[31:2], 2'b00};
            m_id_pc    = 32'h0;
            m_id_instr = NOP;
            m_valid    = 1'b0;
        end else if (fz) begin
            if (m_stall < 65535) m_stall = m_stall + 1;
        end else begin
            m_id_instr = mem_word(m_pc);
            m_pc       = m_pc + 32'd4;
            m_id_pc    = m_pc;
            m_valid    = 1'b1;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_val({tag, " imem_addr"}, imem_addr, m_pc);
        check_val({tag, " id_pc"}, id_pc, m_id_pc);
        check_val({tag, " id_instr"}, id_instr, m_id_instr);
        check_val({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, m_valid});
`ifdef STALL_COUNT_EN
        check_val({tag, " stall_cnt"}, {16'b0, stall_cnt}, m_stall);
`endif
    endtask

    // Drive one cycle of inputs shortly after a rising edge, let the DUT
    // sample them on the next edge, then advance the model to match.
    task automatic applyStimulus(input logic fz, input logic fl, input logic [31:0] ba);
        freeze      = fz;
        flush       = fl;
        branch_addr = ba;
        @(posedge clk);
        #1;
        model_step(fz, fl, ba);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        fz;
        logic        fl;
        logic [31:0] ba;
        logic [31:0] exp_addr;
        logic [31:0] exp_id_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        int unsigned exp_stall;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h4,   32'h4,   32'hE3A0_1005,     1'b1, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h8,   32'h8,   mem_word(32'h4),   1'b1, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h8,   mem_word(32'h4),   1'b1, 1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h8,   mem_word(32'h4),   1'b1, 2};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h8,   mem_word(32'h4),   1'b1, 3};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'hC,   32'hC,   mem_word(32'h8),   1'b1, 3};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'h10,  32'h10,  mem_word(32'hC),   1'b1, 3};
        vecs[7]  = '{1'b0, 1'b1, 32'h40,  32'h40,  32'h0,   NOP,               1'b0, 3};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   32'h44,  32'h44,  mem_word(32'h40),  1'b1, 3};
        vecs[9]  = '{1'b1, 1'b1, 32'h103, 32'h100, 32'h0,   NOP,               1'b0, 3};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   32'h100, 32'h0,   NOP,               1'b0, 4};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   32'h104, 32'h104, mem_word(32'h100), 1'b1, 4};
    end

    initial begin
        rst         = 1'b0;
        freeze      = 1'b0;
        flush       = 1'b0;
        branch_addr = '0;
        model_reset();

        // Reset state, checked against constants.
        #12;
        check_val("reset imem_addr", imem_addr, 32'h0);
        check_val("reset id_pc", id_pc, 32'h0);
        check_val("reset id_instr", id_instr, NOP);
        check_val("reset id_valid", {31'b0, id_valid}, 32'h0);
`ifdef STALL_COUNT_EN
        check_val("reset stall_cnt", {16'b0, stall_cnt}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].fz, vecs[i].fl, vecs[i].ba);
            check_val({tag, " imem_addr"}, imem_addr, vecs[i].exp_addr);
            check_val({tag, " id_pc"}, id_pc, vecs[i].exp_id_pc);
            check_val({tag, " id_instr"}, id_instr, vecs[i].exp_instr);
            check_val({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, vecs[i].exp_valid});
`ifdef STALL_COUNT_EN
            check_val({tag, " stall_cnt"}, {16'b0, stall_cnt}, vecs[i].exp_stall);
`endif
        end

        // PC wraparound from the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        check_val("wrap target", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        check_val("wrap imem_addr", imem_addr, 32'h0);
        check_val("wrap id_pc", id_pc, 32'h0);
        checkOutput("wrap");

        // Freeze pulse strictly between edges must be ignored.
        freeze = 1'b0;
        flush  = 1'b0;
        #2 freeze = 1'b1;
        #2 freeze = 1'b0;
        @(posedge clk);
        #1;
        model_step(1'b0, 1'b0, 32'h0);
        checkOutput("glitch");

        // Asynchronous reset in the middle of a freeze.
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_mid_freeze");
        @(posedge clk);
        #1;
        freeze = 1'b0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        check_val("post_rst instr", id_instr, 32'hE3A0_1005);
        checkOutput("post_rst");

        // Asynchronous reset while a flush request is pending.
        applyStimulus(1'b0, 1'b0, 32'h0);
        flush       = 1'b1;
        branch_addr = 32'h80;
        #2 rst = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_mid_flush");
        @(posedge clk);
        #1;
        flush = 1'b0;
        rst   = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("post_rst2");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic fz, fl;
            logic [31:0] ba;
            fz = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 10);
            ba = $urandom;
            applyStimulus(fz, fl, ba);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
